// File: rtl/axi_read_slave.sv
// Single-outstanding AXI read slave over a 256-word memory with a backdoor write port.
// Optional feature: define AXI_RD_WRAP_EN to support WRAP bursts (otherwise they return SLVERR).
module axi_read_slave #(
    parameter int WIDTH = 32,
    parameter int SIZE  = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [WIDTH/8-1:0]   arid,
    input  logic [WIDTH-1:0]     araddr,
    input  logic [WIDTH/8-1:0]   arlen,
    input  logic [SIZE-1:0]      arsize,
    input  logic [SIZE-2:0]      arburst,
    input  logic                 arvalid,
    output logic                 arready,
    output logic [WIDTH/8-1:0]   rid,
    output logic [WIDTH-1:0]     rdata,
    output logic [SIZE-2:0]      rresp,
    output logic                 rlast,
    output logic                 rvalid,
    input  logic                 rready,
    input  logic                 mem_we,
    input  logic [7:0]           mem_waddr,
    input  logic [WIDTH-1:0]     mem_wdata
);

    // state | meaning
    // IDLE  | address channel open, no beats pending
    // DATA  | burst in progress, rvalid asserted with the current beat
    localparam int IW = WIDTH / 8;
    localparam int BW = SIZE - 1;

    typedef enum logic {IDLE, DATA} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  mem [256];
    logic [WIDTH-1:0]  cur_addr;
    logic [IW-1:0]     cnt_q, len_q;
    logic [SIZE-1:0]   size_q;
    logic [BW-1:0]     burst_q;
    logic              slv_q;

    logic              ld_en, ld_first, ld_slv, ar_slv;
    logic [WIDTH-1:0]  ld_addr;
    logic [BW-1:0]     ld_resp;

    function automatic logic [WIDTH-1:0] next_addr(input logic [WIDTH-1:0] a,
                                                   input logic [SIZE-1:0]  sz,
                                                   input logic [BW-1:0]    bu,
                                                   input logic [IW-1:0]    ln);
        logic [WIDTH-1:0] bytes, span, base, inc;
        bytes = WIDTH'(1) << sz;
        span  = (WIDTH'(ln) + WIDTH'(1)) << sz;
        base  = a & ~(span - WIDTH'(1));
        inc   = (a & ~(bytes - WIDTH'(1))) + bytes;
        if (bu == BW'(0))
            next_addr = a;
        else if ((bu == BW'(2)) && (inc >= base + span))
            next_addr = base;
        else
            next_addr = inc;
    endfunction

    // Slave error is a property of the whole request, so it is decided once at capture.
`ifdef AXI_RD_WRAP_EN
    logic wrap_legal;
    assign wrap_legal = ((arlen == IW'(1)) || (arlen == IW'(3)) || (arlen == IW'(7)) || (arlen == IW'(15)))
                        && ((araddr & ((WIDTH'(1) << arsize) - WIDTH'(1))) == '0);
    assign ar_slv = (arsize > SIZE'(2)) || (arburst == BW'(3)) || ((arburst == BW'(2)) && !wrap_legal);
`else
    assign ar_slv = (arsize > SIZE'(2)) || (arburst == BW'(3)) || (arburst == BW'(2));
`endif

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        arready = 1'b0;
        rvalid  = 1'b0;
        case (state_q)
            IDLE: begin
                arready = 1'b1;
                if (arvalid) state_d = DATA;
            end
            DATA: begin
                rvalid = 1'b1;
                if (rready && rlast) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ld_en    = 1'b0;
        ld_first = 1'b0;
        ld_addr  = cur_addr;
        ld_slv   = slv_q;
        if (state_q == IDLE && arvalid) begin
            ld_en    = 1'b1;
            ld_first = 1'b1;
            ld_addr  = araddr;
            ld_slv   = ar_slv;
        end else if (state_q == DATA && rready && !rlast) begin
            ld_en   = 1'b1;
            ld_addr = next_addr(cur_addr, size_q, burst_q, len_q);
        end
        if (ld_slv)
            ld_resp = BW'(2);
        else if (ld_addr >= WIDTH'(1024))
            ld_resp = BW'(3);
        else
            ld_resp = BW'(0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rid      <= '0;
            rdata    <= '0;
            rresp    <= '0;
            rlast    <= 1'b0;
            cur_addr <= '0;
            cnt_q    <= '0;
            len_q    <= '0;
            size_q   <= '0;
            burst_q  <= '0;
            slv_q    <= 1'b0;
        end else if (ld_en) begin
            cur_addr <= ld_addr;
            rresp    <= ld_resp;
            rdata    <= (ld_resp == BW'(0)) ? mem[ld_addr[9:2]] : '0;
            if (ld_first) begin
                rid     <= arid;
                len_q   <= arlen;
                size_q  <= arsize;
                burst_q <= arburst;
                slv_q   <= ar_slv;
                cnt_q   <= '0;
                rlast   <= (arlen == '0);
            end else begin
                cnt_q <= cnt_q + IW'(1);
                rlast <= ((cnt_q + IW'(1)) == len_q);
            end
        end else if (state_q == DATA && rready && rlast) begin
            rlast <= 1'b0;
        end
    end

    // Beat loads above sample mem before this block's write lands, so a same-cycle write is not seen.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 256; i++)
                mem[i] <= WIDTH'(32'hA500_0000) + WIDTH'(i);
        end else if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule
